feature_mem_loader: RTL and testbench
=====================================

FEATURE_MEM_LOADER -- requirements
Module: feature_mem_loader

Interface
REQ-001 Parameters SHALL be: Tn, default `Tn, number of feature memory groups; KERNEL_SIZE, default `KERNEL_SIZE, lines per group; DATA_BUS_WIDTH, default `DATA_BUS_WIDTH, beat width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle load request
- cfg_groups  in  4  groups to load, legal range 1..Tn
- cfg_lines  in  4  lines per group to load, legal range 1..KERNEL_SIZE
- s_valid  in  1  input beat valid
- s_data  in  DATA_BUS_WIDTH  input beat
- s_ready  out  1  beat accept
- wr_en  out  1  feature memory write strobe
- wr_mem_group  out  4  target group
- wr_mem_line  out  4  target line
- o_port  out  DATA_BUS_WIDTH  write data
- line_done  out  1  pulse: one line written across all groups
- line_idx  out  4  index of the line just completed
- busy  out  1  load in progress
- done  out  1  pulse: load complete
- cfg_err  out  1  pulse: illegal configuration

Function
REQ-004 The FSM SHALL have three states, IDLE, LOAD and FIN, and SHALL reset to IDLE.
REQ-005 In IDLE, start=1 with legal configuration SHALL latch cfg_groups/cfg_lines, clear the group and line counters, and enter LOAD on the next edge.
REQ-006 In IDLE, start=1 with cfg_groups=0, cfg_groups>Tn, cfg_lines=0 or cfg_lines>KERNEL_SIZE SHALL pulse cfg_err for one cycle and stay in IDLE.
REQ-007 start SHALL be ignored in LOAD and FIN.
REQ-008 s_ready SHALL be 1 only in LOAD; a beat is accepted when s_valid=1 and s_ready=1.
REQ-009 Each accepted beat in cycle k SHALL produce, in cycle k+1, wr_en=1 with o_port=s_data and wr_mem_group/wr_mem_line equal to the counter values at k (registered, latency 1).
REQ-010 wr_en SHALL be 0 in every cycle not following an accepted beat; o_port, wr_mem_group and wr_mem_line SHALL hold their last values when wr_en=0.
REQ-011 Write order SHALL be line-major: the group counter increments per accepted beat, 0..cfg_groups-1; at wrap it returns to 0 and the line counter increments, 0..cfg_lines-1.
REQ-012 A beat that writes group cfg_groups-1 SHALL assert line_done in the same cycle as its wr_en, for one cycle, with line_idx equal to that line.
REQ-013 Acceptance of beat cfg_groups*cfg_lines SHALL move the FSM to FIN, so s_ready=0 from the next cycle; no extra beat is accepted.
REQ-014 In FIN, which coincides with the last wr_en cycle, done SHALL pulse for one cycle and the FSM SHALL return to IDLE on the next edge.
REQ-015 busy SHALL be 1 in LOAD and FIN and 0 in IDLE.
REQ-016 Stalls with s_valid=0 in LOAD SHALL freeze the counters with no timeout; stall length SHALL be unbounded.
REQ-017 Counters SHALL be 4 bits wide; with legal configuration no counter overflows.

Reset
REQ-018 Asserting rst low SHALL immediately force IDLE, counters=0, s_ready=0, wr_en=0, line_done=0, done=0, cfg_err=0, busy=0, wr_mem_group=0, wr_mem_line=0, line_idx=0 and o_port=0.
REQ-019 Reset asserted mid-LOAD SHALL abort the load without a done pulse; a pending registered write SHALL be discarded (no wr_en after release).
REQ-020 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-021 Scenarios:
- V1: Tn=4, KERNEL_SIZE=3; start with cfg_groups=4, cfg_lines=3, s_valid held 1 and data 0..11 -> 12 wr_en cycles, (group,line) sequence (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2), o_port 0..11; line_done on beats 4, 8 and 12 with line_idx 0,1,2; done coincides with the 12th wr_en; s_ready low after the 12th accept.
- V2: cfg_groups=2, cfg_lines=1, s_valid toggling 1,0,0,1 -> exactly 2 writes, to (0,0) and (1,0), each one cycle after its accept; counters frozen during the gaps.
- V3: start with cfg_groups=0, then with cfg_lines=KERNEL_SIZE+1 -> cfg_err pulses once per request, busy stays 0, no wr_en.
- V4: rst low after 5 accepted beats of V1 -> all outputs 0 immediately, no further wr_en, no done; new start after release runs V1 correctly from (0,0).
- V5: start asserted during LOAD -> no effect; the transfer count and order are unchanged.
- V6: back-to-back loads, with start in the cycle after done -> second load begins cleanly at (0,0); no beat is lost or duplicated.

Source files
------------

// File: rtl/feature_mem_loader.sv
// ---------------------------------------------------------------------------
// feature_mem_loader
//
// Streams input beats into a bank of Tn feature-memory groups, each holding
// KERNEL_SIZE lines. One load writes cfg_groups x cfg_lines beats in
// line-major order. For each line, the group index sweeps 0..cfg_groups-1,
// then the line index advances. Every accepted beat produces one registered
// write strobe in the following cycle.
//
// Ports
//   clk           clock
//   rst           asynchronous active-low reset
//   start         one-cycle load request (sampled only in IDLE)
//   cfg_groups    groups to load, legal 1..Tn
//   cfg_lines     lines per group, legal 1..KERNEL_SIZE
//   s_valid       input beat valid
//   s_data        input beat
//   s_ready       beat accept (high only while loading)
//   wr_en         feature memory write strobe
//   wr_mem_group  target group of the write
//   wr_mem_line   target line of the write
//   o_port        write data
//   line_done     pulse with the write that completes a line in all groups
//   line_idx      index of the line just completed
//   busy          load in progress
//   done          pulse: load complete (coincides with the last write)
//   cfg_err       pulse, one cycle after an illegal start request
// ---------------------------------------------------------------------------
`ifndef Tn
`define Tn 4
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 16
`endif

module feature_mem_loader #(
    parameter int Tn             = `Tn,
    parameter int KERNEL_SIZE    = `KERNEL_SIZE,
    parameter int DATA_BUS_WIDTH = `DATA_BUS_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                cfg_groups,
    input  logic [3:0]                cfg_lines,
    input  logic                      s_valid,
    input  logic [DATA_BUS_WIDTH-1:0] s_data,
    output logic                      s_ready,
    output logic                      wr_en,
    output logic [3:0]                wr_mem_group,
    output logic [3:0]                wr_mem_line,
    output logic [DATA_BUS_WIDTH-1:0] o_port,
    output logic                      line_done,
    output logic [3:0]                line_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [3:0] TN_MAX = 4'(Tn);
    localparam logic [3:0] KS_MAX = 4'(KERNEL_SIZE);

    state_t r_state;
    state_t w_next_state;

    logic [3:0]                r_groups;
    logic [3:0]                r_lines;
    logic [3:0]                r_grp_cnt;
    logic [3:0]                r_line_cnt;
    logic                      r_wr_en;
    logic [3:0]                r_wr_group;
    logic [3:0]                r_wr_line;
    logic [DATA_BUS_WIDTH-1:0] r_o_port;
    logic                      r_line_done;
    logic [3:0]                r_line_idx;
    logic                      r_cfg_err;

    logic w_cfg_ok;
    logic w_start_ok;
    logic w_accept;
    logic w_last_grp;
    logic w_last_beat;
    logic w_s_ready;
    logic w_busy;
    logic w_done;

    assign w_cfg_ok    = (cfg_groups != 4'd0) && (cfg_groups <= TN_MAX) &&
                         (cfg_lines  != 4'd0) && (cfg_lines  <= KS_MAX);
    assign w_start_ok  = (r_state == IDLE) && start && w_cfg_ok;
    assign w_accept    = s_valid && w_s_ready;
    assign w_last_grp  = (r_grp_cnt == r_groups - 4'd1);
    assign w_last_beat = w_last_grp && (r_line_cnt == r_lines - 4'd1);

    // ---- FSM: state register ----------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---- FSM: next-state logic --------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next_state = LOAD;
            LOAD:    if (w_accept && w_last_beat) w_next_state = FIN;
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---- FSM: state-decoded outputs ---------------------------------------
    // FIN lasts exactly one cycle: the cycle in which the final write strobe
    // is presented, so done lines up with that write.
    always_comb begin
        w_s_ready = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            LOAD: begin
                w_s_ready = 1'b1;
                w_busy    = 1'b1;
            end
            FIN: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // ---- Counters and registered write port -------------------------------
    // The counter values at acceptance are the write address, so they are
    // copied into the write registers before they advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_groups    <= 4'd0;
            r_lines     <= 4'd0;
            r_grp_cnt   <= 4'd0;
            r_line_cnt  <= 4'd0;
            r_wr_en     <= 1'b0;
            r_wr_group  <= 4'd0;
            r_wr_line   <= 4'd0;
            r_o_port    <= '0;
            r_line_done <= 1'b0;
            r_line_idx  <= 4'd0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_wr_en     <= w_accept;
            r_line_done <= w_accept && w_last_grp;
            r_cfg_err   <= (r_state == IDLE) && start && !w_cfg_ok;

            if (w_start_ok) begin
                r_groups   <= cfg_groups;
                r_lines    <= cfg_lines;
                r_grp_cnt  <= 4'd0;
                r_line_cnt <= 4'd0;
            end else if (w_accept) begin
                r_o_port   <= s_data;
                r_wr_group <= r_grp_cnt;
                r_wr_line  <= r_line_cnt;
                if (w_last_grp) begin
                    r_grp_cnt  <= 4'd0;
                    r_line_cnt <= r_line_cnt + 4'd1;
                    r_line_idx <= r_line_cnt;
                end else begin
                    r_grp_cnt <= r_grp_cnt + 4'd1;
                end
            end
        end
    end

    assign s_ready      = w_s_ready;
    assign busy         = w_busy;
    assign done         = w_done;
    assign wr_en        = r_wr_en;
    assign wr_mem_group = r_wr_group;
    assign wr_mem_line  = r_wr_line;
    assign o_port       = r_o_port;
    assign line_done    = r_line_done;
    assign line_idx     = r_line_idx;
    assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_feature_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_feature_mem_loader
//
// Self-checking bench for feature_mem_loader (Tn=4, KERNEL_SIZE=3, 16-bit
// beats). Expected writes come from the line-major rule: beat b of a load
// with G groups goes to group b%G, line b/G, closes a line when b%G==G-1,
// and finishes the load when b==G*L-1. Outputs are sampled 1 time unit after
// each rising edge; inputs are driven at the same point.
// ---------------------------------------------------------------------------
module tb_feature_mem_loader;

    localparam int TN = 4;
    localparam int KS = 3;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [3:0]    cfg_groups;
    logic [3:0]    cfg_lines;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          wr_en;
    logic [3:0]    wr_mem_group;
    logic [3:0]    wr_mem_line;
    logic [DW-1:0] o_port;
    logic          line_done;
    logic [3:0]    line_idx;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    feature_mem_loader #(
        .Tn             (TN),
        .KERNEL_SIZE    (KS),
        .DATA_BUS_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_groups   (cfg_groups),
        .cfg_lines    (cfg_lines),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .wr_en        (wr_en),
        .wr_mem_group (wr_mem_group),
        .wr_mem_line  (wr_mem_line),
        .o_port       (o_port),
        .line_done    (line_done),
        .line_idx     (line_idx),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"},   s_ready,      0);
        check({tag, "_wr_en"},     wr_en,        0);
        check({tag, "_line_done"}, line_done,    0);
        check({tag, "_done"},      done,         0);
        check({tag, "_cfg_err"},   cfg_err,      0);
        check({tag, "_busy"},      busy,         0);
        check({tag, "_group"},     wr_mem_group, 0);
        check({tag, "_line"},      wr_mem_line,  0);
        check({tag, "_line_idx"},  line_idx,     0);
        check({tag, "_o_port"},    o_port,       0);
    endtask

    // One complete load of g groups x l lines, checked beat by beat.
    // gap_pct: chance (percent) of s_valid=0 per cycle when no pattern is used.
    // seq_data: beat data equals beat number; otherwise random.
    // use_pat/vpat: s_valid follows vpat[cycle%4].
    // poke: drive random start/cfg during LOAD and a legal start during FIN.
    task automatic run_load(input int g, input int l, input int gap_pct,
                            input bit seq_data, input bit use_pat,
                            input logic [3:0] vpat, input bit poke);
        int            total;
        int            n;
        int            cyc;
        logic          acc;
        logic [DW-1:0] d;
        total = g * l;
        n     = 0;
        cyc   = 0;

        start      = 1'b1;
        cfg_groups = 4'(g);
        cfg_lines  = 4'(l);
        s_valid    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("load_busy",  busy,    1);
        check("load_ready", s_ready, 1);
        check("load_no_wr", wr_en,   0);

        while (n < total && cyc < 2000) begin
            if (use_pat) s_valid = vpat[cyc % 4];
            else         s_valid = ($urandom_range(0, 99) >= gap_pct);
            d      = seq_data ? DW'(n) : DW'($urandom);
            s_data = d;
            if (poke) begin
                start      = 1'($urandom_range(0, 1));
                cfg_groups = 4'($urandom_range(0, 15));
                cfg_lines  = 4'($urandom_range(0, 15));
            end
            acc = s_valid;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                check("wr_en",     wr_en,        1);
                check("wr_group",  wr_mem_group, n % g);
                check("wr_line",   wr_mem_line,  n / g);
                check("wr_data",   o_port,       d);
                check("line_done", line_done,    (n % g) == (g - 1));
                if ((n % g) == (g - 1)) check("line_idx", line_idx, n / g);
                check("done",      done,         n == total - 1);
                n++;
            end else begin
                check("wr_idle",   wr_en,     0);
                check("done_idle", done,      0);
                check("ld_idle",   line_done, 0);
            end
            check("ready",       s_ready, n < total);
            check("busy",        busy,    1);
            check("no_cfg_err",  cfg_err, 0);
        end
        check("load_complete", n, total);

        // FIN cycle: offer one more beat (must not be taken) and, when poking,
        // a legal start (must be ignored).
        s_valid    = 1'b1;
        s_data     = DW'($urandom);
        start      = poke;
        cfg_groups = 4'(g);
        cfg_lines  = 4'(l);
        @(posedge clk); #1;
        check("extra_wr",  wr_en, 0);
        check("post_busy", busy,  0);
        check("post_done", done,  0);
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic err_req(input int g, input int l);
        start      = 1'b1;
        cfg_groups = 4'(g);
        cfg_lines  = 4'(l);
        @(posedge clk); #1;
        start = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy",  busy,    0);
        check("cfg_err_wr",    wr_en,   0);
        @(posedge clk); #1;
        check("cfg_err_clear", cfg_err, 0);
        check("cfg_err_idle",  busy,    0);
        check("cfg_err_ready", s_ready, 0);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        cfg_groups = 4'd0;
        cfg_lines  = 4'd0;
        s_valid    = 1'b0;
        s_data     = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // V1: full 4x3 load, data 0..11, start on the first edge after release
        run_load(4, 3, 0, 1'b1, 1'b0, 4'b0000, 1'b0);

        // V3: illegal configurations
        err_req(0, 3);
        err_req(4, KS + 1);
        err_req(TN + 1, 1);
        err_req(2, 0);

        // V2: 2x1 with s_valid pattern 1,0,0,1
        run_load(2, 1, 0, 1'b0, 1'b1, 4'b1001, 1'b0);

        // V4: reset after 5 accepted beats with a 6th beat in flight
        start      = 1'b1;
        cfg_groups = 4'd4;
        cfg_lines  = 4'd3;
        @(posedge clk); #1;
        start   = 1'b0;
        s_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            s_data = DW'(b + 100);
            @(posedge clk); #1;
            check("v4_wr",    wr_en,        1);
            check("v4_group", wr_mem_group, b % 4);
            check("v4_data",  o_port,       b + 100);
        end
        s_data = DW'(105);
        rst    = 1'b0;
        #1;
        check_all_zero("v4_rst");
        s_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("v4_hold_wr",   wr_en, 0);
            check("v4_hold_done", done,  0);
        end
        rst = 1'b1;
        run_load(4, 3, 0, 1'b1, 1'b0, 4'b0000, 1'b0);

        // V5: random start/cfg activity during LOAD and FIN
        run_load(3, 3, 30, 1'b0, 1'b0, 4'b0000, 1'b1);
        run_load(4, 2, 50, 1'b0, 1'b0, 4'b0000, 1'b1);

        // V6: back-to-back loads with random shapes and stalls
        for (int i = 0; i < 8; i++) begin
            run_load($urandom_range(1, TN), $urandom_range(1, KS),
                     $urandom_range(0, 60), 1'b0, 1'b0, 4'b0000, 1'b0);
        end
        run_load(1, 1, 0, 1'b0, 1'b0, 4'b0000, 1'b0);
        run_load(TN, KS, 80, 1'b0, 1'b0, 4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
